// File: rtl/mems_spi_rx_if.sv
// rtl/mems_spi_rx_if.sv - SPI pins and received-word handshake for mems_spi_rx.
interface mems_spi_rx_if #(
  parameter int DATA_W = 24
);
  logic              sck;
  logic              mosi;
  logic              cs;
  logic              data_ack;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              new_data;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport slave (
    input  sck, mosi, cs, data_ack,
    output data_out, data_valid, new_data, frame_err, overrun, busy
  );

  modport master (
    output sck, mosi, cs, data_ack,
    input  data_out, data_valid, new_data, frame_err, overrun, busy
  );
endinterface

// File: rtl/mems_spi_rx.sv
// rtl/mems_spi_rx.sv - SPI slave receiver (sample on sck fall, MSB first) with frame-length check.
module mems_spi_rx #(
  parameter int DATA_W = 24
) (
  input  logic          clk,
  input  logic          rst,
  mems_spi_rx_if.slave  bus
);
  localparam int CW = $clog2(DATA_W + 2);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              new_data_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              armed_q;

  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic mosi_s1_q, mosi_s2_q;
  logic [1:0] fill_q;

  logic sck_fall, cs_fall, cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      fill_q    <= 2'b00;
    end else begin
      sck_s1_q  <= bus.sck;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      cs_s1_q   <= bus.cs;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= bus.mosi;
      mosi_s2_q <= mosi_s1_q;
      fill_q    <= {fill_q[0], 1'b1};
    end
  end

  assign sck_fall = sck_s3_q & ~sck_s2_q;
  assign cs_fall  = cs_s3_q & ~cs_s2_q;
  assign cs_rise  = ~cs_s3_q & cs_s2_q;

  // The synchronizer resets to cs=1, so a cs held low through reset would look
  // like a fresh falling edge; frames are only accepted once real cs high is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      new_data_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fill_q[1] && cs_s2_q) armed_q <= 1'b1;
      // An ack seen while new_data is showing belongs to the previous word.
      if (bus.data_ack && !new_data_q) data_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          shreg_q <= '0;
          if (cs_fall && armed_q) state_q <= RECV;
        end
        RECV: begin
          if (sck_fall) begin
            shreg_q <= {shreg_q[DATA_W-2:0], mosi_s2_q};
            if (cnt_q != CW'(DATA_W + 1)) cnt_q <= cnt_q + CW'(1);
          end
          if (cs_rise) state_q <= CHECK;
        end
        CHECK: begin
          if (cnt_q == CW'(DATA_W)) begin
            data_out_q   <= shreg_q;
            new_data_q   <= 1'b1;
            data_valid_q <= 1'b1;
            if (data_valid_q && !bus.data_ack) overrun_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.new_data   = new_data_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = ~cs_s2_q;
endmodule
